// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-coded copy of the count.
// bin, gray and wrap share one register stage; at_end is the only output with a combinational path from an input (up).
module gray_counter #(
    parameter int W    = 4,
    parameter bit WRAP = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         load,
    input  logic [W-1:0] load_bin,
    output logic [W-1:0] bin,
    output logic [W-1:0] gray,
    output logic         wrap,
    output logic         at_end
);

    localparam logic [W:0]   ONE_W1  = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] ALL_ONE = {W{1'b1}};
    localparam logic [W-1:0] ALL_ZER = {W{1'b0}};

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [W-1:0] bin_q, bin_d;
    logic [W-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic [W:0]   step_s;

    // Next-state selection: load beats count, count beats hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (up) begin
            step_s = {1'b0, bin_q} + ONE_W1;
        end else begin
            step_s = {1'b0, bin_q} - ONE_W1;
        end
        if (load) begin
            bin_d  = load_bin;
            wrap_d = 1'b0;
        end else if (en) begin
            // Bit W is set only when the step crosses an end value (carry up or borrow down).
            if (step_s[W]) begin
                wrap_d = 1'b1;
                if (WRAP) begin
                    bin_d = step_s[W-1:0];
                end else begin
                    bin_d = bin_q;
                end
            end else begin
                bin_d  = step_s[W-1:0];
                wrap_d = 1'b0;
            end
        end else begin
            bin_d  = bin_q;
            wrap_d = 1'b0;
        end
        gray_d = bin2gray(bin_d);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q  <= ALL_ZER;
            gray_q <= ALL_ZER;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    // End-value flag follows the live direction through the registered count.
    always_comb begin
        if (up) begin
            at_end = (bin_q == ALL_ONE);
        end else begin
            at_end = (bin_q == ALL_ZER);
        end
    end

    assign bin  = bin_q;
    assign gray = gray_q;
    assign wrap = wrap_q;

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Up/down binary counter that publishes a registered Gray-coded value.
- Produces the 4-bit Gray streams that the team's existing Gray-to-binary decoder consumes, e.g. async-FIFO pointers and encoder position emulation.
- Gray and binary outputs are registered together, so both describe the same count in the same cycle.
- Adjacent Gray outputs differ in exactly one bit, except on load.

Parameters:
- W, 4, counter and code width in bits (W >= 2).
- WRAP, 1, 1 = modulo-2^W wrap-around; 0 = saturate at the end values.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when stepping.
- load  input  1  synchronous load strobe.
- load_bin  input  W  binary value applied on load.
- bin  output  W  registered binary count.
- gray  output  W  registered Gray code of bin: gray = bin ^ (bin >> 1).
- wrap  output  1  one-cycle pulse: the count wrapped (WRAP=1) or a step was blocked at an end value (WRAP=0).
- at_end  output  1  registered: bin == 2^W-1 when up=1, bin == 0 when up=0; tracks up combinationally through the registered bin.

Behaviour:
- Reset: one clock is used; reset is synchronous and active-low (rst_n), sampled on the rising edge of clk.
  - rst_n low at a clk edge sets bin=0, gray=0, wrap=0. at_end then follows bin and up.
  - Reset has priority over load and en.
  - Reset asserted mid-count clears bin, gray and wrap on that same edge; there is no partial update.
- Priority each edge: reset > load > en > hold.
- Load:
  - bin <= load_bin; gray <= load_bin ^ (load_bin >> 1); wrap <= 0.
  - en is ignored in a load cycle.
  - Load is the only event that may change more than one gray bit.
- Count (en=1, load=0):
  - next = bin+1 if up, else bin-1, computed at W+1 bits.
  - WRAP=1:
    - Step from 2^W-1 up gives 0. Step from 0 down gives 2^W-1.
    - wrap=1 for exactly the cycle after that edge.
  - WRAP=0:
    - At 2^W-1 with up=1, or 0 with up=0, bin and gray hold.
    - wrap=1 for the cycle after each blocked step.
  - gray is always derived from the next binary value inside the same register stage. It is never computed from the registered bin, which would add a cycle of lag.
- Hold (en=0, load=0): bin and gray keep their values; wrap <= 0.
- Latency:
  - An input sampled at edge N is visible on bin and gray after edge N.
  - wrap is valid in the same cycle as the wrapped or blocked value.
- Direction change: up may toggle on any cycle. The step direction is the up value sampled at that edge; no extra cycle is added.
- Single-bit property: for any non-load, non-reset edge, popcount(gray_prev ^ gray_next) is 1 on a step and 0 on a hold.
- No combinational path from inputs to bin, gray or wrap. at_end is the only output that depends combinationally on an input (up).

Test Plan:
- Reset then count: rst_n=0 for 2 cycles, then en=1, up=1 for 16 cycles (W=4). Gray sequence is 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with wrap=1 for one cycle. Every transition flips exactly one bit. Feeding gray into the existing decoder returns bin each cycle.
- Down wrap: load load_bin=0001, then en=1, up=0 for 2 cycles. Sequence is bin=1/gray=0001, bin=0/gray=0000, bin=15/gray=1000, with wrap=1 in the cycle showing bin=15.
- Load priority: bin=3, then load=1, en=1, up=1, load_bin=1010. Next cycle bin=1010, gray=1111, wrap=0; no increment is applied.
- Saturation (WRAP=0): load 1110, then en=1, up=1 for 3 cycles. bin=1111/gray=1000 holds for 2 cycles, with wrap=1 each blocked cycle and at_end=1. Then up=0 gives bin=1110, gray=1001.
- Reset mid-operation: counting up, at bin=0110 assert rst_n=0 with load=1 and en=1 on the same edge. Next cycle bin=0, gray=0, wrap=0. After release, counting resumes from 0 to 0001.
- Hold and direction toggle: en alternates 1/0 while up toggles every step, starting at bin=5 (gray 0111). Sequence is 5→6→5→6, each step one cycle after its enable. gray does not change on en=0 cycles.
